// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU data bus: stalls the CPU while it moves 1..6 bytes
// serially to or from an internal byte-wide RAM, assembling little-endian read data.
module cpu_mem_responder #(
    parameter int MEM_ADDR_BITS = 16,
    parameter int WAIT_CYCLES   = 2,
    parameter int BUS_WIDTH     = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic [31:0]          req_addr,
    input  logic [BUS_WIDTH-1:0] req_wdata,
    output logic [BUS_WIDTH-1:0] rdata,
    output logic                 cpu_enable,
    output logic                 resp_valid,
    output logic                 bus_error
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

    localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? WW'(WAIT_CYCLES - 1) : '0;
    localparam logic [32:0] MEM_LIMIT = 33'd1 << MEM_ADDR_BITS;

    state_t                   state_r, state_next_s;
    logic                     we_r;
    logic                     err_r, err_next_s;
    logic [2:0]               nbytes_r, req_n_s;
    logic [2:0]               byte_cnt_r;
    logic [WW-1:0]            wait_cnt_r;
    logic [MEM_ADDR_BITS-1:0] addr_r, cur_addr_s;
    logic [BUS_WIDTH-1:0]     wdata_r;
    logic [32:0]              last_addr_s;
    logic                     range_ok_s;
    logic [7:0]               wbyte_s, ram_q_s;
    logic [7:0]               mem [2**MEM_ADDR_BITS];

    assign cur_addr_s = addr_r + MEM_ADDR_BITS'(byte_cnt_r);
    assign ram_q_s    = mem[cur_addr_s];
    assign cpu_enable = ((state_r == S_IDLE) && !req_valid) || (state_r == S_DONE);

    // Request size decode and range check on the request as presented
    always_comb begin
        req_n_s = 3'd1;
        case (req_size)
            2'd0:    req_n_s = 3'd1;
            2'd1:    req_n_s = 3'd2;
            2'd2:    req_n_s = 3'd4;
            2'd3:    req_n_s = 3'd6;
            default: req_n_s = 3'd1;
        endcase
        // 33-bit sum so a transfer wrapping past 0xFFFFFFFF is rejected
        last_addr_s = {1'b0, req_addr} + {30'd0, req_n_s} - 33'd1;
        range_ok_s  = (last_addr_s < MEM_LIMIT);
    end

    // Select the write byte for the current transfer position
    always_comb begin
        wbyte_s = 8'h00;
        case (byte_cnt_r)
            3'd0:    wbyte_s = wdata_r[7:0];
            3'd1:    wbyte_s = wdata_r[15:8];
            3'd2:    wbyte_s = wdata_r[23:16];
            3'd3:    wbyte_s = wdata_r[31:24];
            3'd4:    wbyte_s = wdata_r[39:32];
            3'd5:    wbyte_s = wdata_r[47:40];
            default: wbyte_s = 8'h00;
        endcase
    end

    // Next-state logic; rejected requests still sit out the wait states, then skip XFER
    always_comb begin
        state_next_s = state_r;
        err_next_s   = err_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    err_next_s = !range_ok_s;
                    if (WAIT_CYCLES > 0) begin
                        state_next_s = S_WAIT;
                    end else if (range_ok_s) begin
                        state_next_s = S_XFER;
                    end else begin
                        state_next_s = S_DONE;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_cnt_r == '0) begin
                    state_next_s = err_r ? S_DONE : S_XFER;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_XFER: begin
                if (byte_cnt_r == nbytes_r - 3'd1) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_XFER;
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, request latch, counters and registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            we_r       <= 1'b0;
            err_r      <= 1'b0;
            nbytes_r   <= 3'd1;
            byte_cnt_r <= 3'd0;
            wait_cnt_r <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            rdata      <= '0;
            resp_valid <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            err_r      <= err_next_s;
            resp_valid <= (state_next_s == S_DONE);
            bus_error  <= (state_next_s == S_DONE) && err_next_s;
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        we_r       <= req_we;
                        nbytes_r   <= req_n_s;
                        addr_r     <= req_addr[MEM_ADDR_BITS-1:0];
                        wdata_r    <= req_wdata;
                        rdata      <= '0;
                        byte_cnt_r <= 3'd0;
                        wait_cnt_r <= WAIT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_r != '0) begin
                        wait_cnt_r <= wait_cnt_r - WW'(1);
                    end
                end
                S_XFER: begin
                    if (!we_r) begin
                        for (int i = 0; i < 6; i++) begin
                            if (byte_cnt_r == 3'(i)) begin
                                rdata[8*i +: 8] <= ram_q_s;
                            end
                        end
                    end
                    byte_cnt_r <= byte_cnt_r + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // RAM write port; contents are not reset, and a reset edge suppresses the pending byte
    always_ff @(posedge clk) begin
        if (!rst && (state_r == S_XFER) && we_r) begin
            mem[cur_addr_s] <= wbyte_s;
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed testbench for cpu_mem_responder (default parameters: 64 KiB RAM, 2 wait states).
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [47:0] req_wdata;
    logic [47:0] rdata;
    logic        cpu_enable;
    logic        resp_valid;
    logic        bus_error;

    int tests_run    = 0;
    int tests_failed = 0;

    cpu_mem_responder dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .cpu_enable(cpu_enable), .resp_valid(resp_valid),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    // One complete access; request dropped and fields scrambled after the accept cycle
    task automatic access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [47:0] wd, output logic [47:0] rd, output logic err,
                          output int stall);
        logic done;
        done  = 1'b0;
        stall = 0;
        rd    = 48'h0;
        err   = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (resp_valid) begin
                done = 1'b1;
                rd   = rdata;
                err  = bus_error;
                tests_run++;
                if (cpu_enable !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL done_enable: got %b expected 1", cpu_enable);
                end
            end else begin
                stall++;
            end
            @(negedge clk);
            req_valid = 1'b0; req_addr = 32'hDEAD_BEEF; req_wdata = 48'h123456789ABC;
            req_size = 2'd3; req_we = ~we;
        end
        req_we = 1'b0;
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL access_timeout: no resp_valid for addr %h", addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_addr = 32'h0; req_wdata = 48'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run += 4;
        if (rdata !== 48'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp: got %b expected 0", resp_valid); end
        if (bus_error !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", bus_error); end
        if (cpu_enable !== 1'b1) begin tests_failed++; $display("FAIL reset_enable: got %b expected 1", cpu_enable); end
    endtask

    task automatic test_read32();
        logic [47:0] rd; logic err; int st;
        access(1'b1, 2'd2, 32'h10, 48'h0000_4433_2211, rd, err, st);
        tests_run++;
        if (st !== 7) begin tests_failed++; $display("FAIL wr32_stall: got %0d expected 7", st); end
        access(1'b0, 2'd2, 32'h10, 48'h0, rd, err, st);
        tests_run += 3;
        if (rd !== 48'h0000_4433_2211) begin tests_failed++; $display("FAIL rd32_data: got %h expected 000044332211", rd); end
        if (st !== 7) begin tests_failed++; $display("FAIL rd32_stall: got %0d expected 7", st); end
        if (err !== 1'b0) begin tests_failed++; $display("FAIL rd32_err: got %b expected 0", err); end
    endtask

    task automatic test_misaligned();
        logic [47:0] rd; logic err; int st;
        access(1'b1, 2'd1, 32'h21, 48'h0000_0000_BEEF, rd, err, st);
        access(1'b0, 2'd0, 32'h21, 48'h0, rd, err, st);
        tests_run++;
        if (rd !== 48'h0000_0000_00EF) begin tests_failed++; $display("FAIL mis_byte0: got %h expected ef", rd); end
        access(1'b0, 2'd0, 32'h22, 48'h0, rd, err, st);
        tests_run++;
        if (rd !== 48'h0000_0000_00BE) begin tests_failed++; $display("FAIL mis_byte1: got %h expected be", rd); end
        access(1'b0, 2'd1, 32'h21, 48'h0, rd, err, st);
        tests_run += 2;
        if (rd !== 48'h0000_0000_BEEF) begin tests_failed++; $display("FAIL mis_rd16: got %h expected beef", rd); end
        if (st !== 5) begin tests_failed++; $display("FAIL mis_stall: got %0d expected 5", st); end
    endtask

    task automatic test_read48();
        logic [47:0] rd; logic err; int st;
        access(1'b1, 2'd3, 32'h100, 48'h0605_0403_0201, rd, err, st);
        access(1'b0, 2'd3, 32'h100, 48'h0, rd, err, st);
        tests_run += 2;
        if (rd !== 48'h0605_0403_0201) begin tests_failed++; $display("FAIL rd48_data: got %h expected 060504030201", rd); end
        if (st !== 9) begin tests_failed++; $display("FAIL rd48_stall: got %0d expected 9", st); end
        access(1'b0, 2'd2, 32'h101, 48'h0, rd, err, st);
        tests_run++;
        if (rd !== 48'h0000_0504_0302) begin tests_failed++; $display("FAIL rd32_zext: got %h expected 000005040302", rd); end
    endtask

    task automatic test_range_error();
        logic [47:0] rd; logic err; int st;
        access(1'b0, 2'd2, 32'hFFFE, 48'h0, rd, err, st);
        tests_run += 3;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL oor_err: got %b expected 1", err); end
        if (rd !== 48'h0) begin tests_failed++; $display("FAIL oor_rdata: got %h expected 0", rd); end
        if (st !== 3) begin tests_failed++; $display("FAIL oor_stall: got %0d expected 3", st); end
        access(1'b1, 2'd1, 32'hFFFE, 48'h0000_0000_A55A, rd, err, st);
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL edge16_err: got %b expected 0", err); end
        access(1'b0, 2'd0, 32'hFFFF, 48'h0, rd, err, st);
        tests_run += 2;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL edge8_err: got %b expected 0", err); end
        if (rd !== 48'h0000_0000_00A5) begin tests_failed++; $display("FAIL edge8_data: got %h expected a5", rd); end
        access(1'b0, 2'd1, 32'hFFFF_FFFF, 48'h0, rd, err, st);
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL wrap_err: got %b expected 1", err); end
        access(1'b1, 2'd0, 32'h0001_0000, 48'h0000_0000_0099, rd, err, st);
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL oor_wr_err: got %b expected 1", err); end
    endtask

    task automatic test_reset_mid_write();
        logic [47:0] rd; logic err; int st; int resp_seen;
        access(1'b1, 2'd0, 32'h40, 48'h0, rd, err, st);
        access(1'b1, 2'd0, 32'h41, 48'h5A, rd, err, st);
        resp_seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h40;
        req_wdata = 48'h0000_AABB_CCDD;
        // cycles 0 accept, 1-2 wait, 3-4 first two XFER bytes; reset at end of cycle 4
        for (int c = 0; c < 5; c++) begin
            #1;
            if (resp_valid) resp_seen++;
            @(negedge clk);
            req_valid = 1'b0;
            if (c == 3) rst = 1'b1;
        end
        rst = 1'b0;
        #1;
        if (resp_valid) resp_seen++;
        tests_run += 3;
        if (cpu_enable !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_enable: got %b expected 1", cpu_enable); end
        if (resp_seen !== 0) begin tests_failed++; $display("FAIL rst_mid_resp: got %0d expected 0", resp_seen); end
        if (rdata !== 48'h0) begin tests_failed++; $display("FAIL rst_mid_rdata: got %h expected 0", rdata); end
        access(1'b0, 2'd1, 32'h40, 48'h0, rd, err, st);
        tests_run++;
        if (rd !== 48'h0000_0000_5ADD) begin tests_failed++; $display("FAIL rst_mid_ram: got %h expected 5add", rd); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] rd; logic err; int st;
        int resp_cnt; int first_c; int second_c; logic [47:0] first_d; logic [47:0] second_d;
        logic en5;
        access(1'b1, 2'd0, 32'h50, 48'h77, rd, err, st);
        access(1'b1, 2'd0, 32'h51, 48'h88, rd, err, st);
        resp_cnt = 0; first_c = -1; second_c = -1; first_d = 48'h0; second_d = 48'h0; en5 = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_addr = 32'h50;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (c == 5) en5 = cpu_enable;
            if (resp_valid) begin
                resp_cnt++;
                if (resp_cnt == 1) begin first_c = c; first_d = rdata; end
                if (resp_cnt == 2) begin second_c = c; second_d = rdata; end
            end
            @(negedge clk);
            if (c == 4) req_addr = 32'h51;
            if (c == 5) req_valid = 1'b0;
        end
        tests_run += 6;
        if (resp_cnt !== 2) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 2", resp_cnt); end
        if (first_c !== 4) begin tests_failed++; $display("FAIL b2b_first_cycle: got %0d expected 4", first_c); end
        if (second_c !== 9) begin tests_failed++; $display("FAIL b2b_second_cycle: got %0d expected 9", second_c); end
        if (first_d !== 48'h77) begin tests_failed++; $display("FAIL b2b_first_data: got %h expected 77", first_d); end
        if (second_d !== 48'h88) begin tests_failed++; $display("FAIL b2b_second_data: got %h expected 88", second_d); end
        if (en5 !== 1'b0) begin tests_failed++; $display("FAIL b2b_restall: got %b expected 0", en5); end
    endtask

    initial begin
        test_reset();
        test_read32();
        test_misaligned();
        test_read48();
        test_range_error();
        test_reset_mid_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
